// File: rtl/girlanda_multi.sv
// N-pair red/green LED garland: debounced button cycles five light patterns,
// pattern steps paced by a clock divider; all LED outputs registered.
module girlanda_multi #(
  parameter int N_LEDS   = 4,
  parameter int STEP_DIV = 8,
  parameter int DEBOUNCE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              button,
  output logic [N_LEDS-1:0] red,
  output logic [N_LEDS-1:0] green,
  output logic [2:0]        mode
);

  localparam int PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int DW = $clog2(STEP_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [2:0] {
    RUN_RED   = 3'd0,
    RUN_GREEN = 3'd1,
    ALTERNATE = 3'd2,
    BOUNCE    = 3'd3,
    BLINK     = 3'd4
  } mode_t;

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  logic              btn_s1, btn_s2, btn_deb;
  logic [CW-1:0]     deb_cnt;
  logic              press, tick;
  mode_t             mode_q, mode_d;
  dir_t              dir_q, dir_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic              phase_q, phase_d;
  logic [DW-1:0]     div_q, div_d;
  logic [N_LEDS-1:0] onehot, even_mask, red_d, green_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1  <= 1'b1;
      btn_s2  <= 1'b1;
      btn_deb <= 1'b1;
      deb_cnt <= '0;
    end else begin
      btn_s1 <= button;
      btn_s2 <= btn_s1;
      if (btn_s2 == btn_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CW'(DEBOUNCE - 1)) begin
        btn_deb <= btn_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Press fires in the same cycle the debounced level accepts the 1->0 change.
  assign press = btn_deb & ~btn_s2 & (deb_cnt == CW'(DEBOUNCE - 1));
  assign tick  = (div_q == DW'(STEP_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= RUN_RED;
      dir_q   <= UP;
      pos_q   <= '0;
      phase_q <= 1'b0;
      div_q   <= '0;
      red     <= '0;
      green   <= '0;
    end else begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      red     <= red_d;
      green   <= green_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    phase_d = phase_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    if (press) begin
      case (mode_q)
        RUN_RED:   mode_d = RUN_GREEN;
        RUN_GREEN: mode_d = ALTERNATE;
        ALTERNATE: mode_d = BOUNCE;
        BOUNCE:    mode_d = BLINK;
        default:   mode_d = RUN_RED;
      endcase
      dir_d   = UP;
      pos_d   = '0;
      phase_d = 1'b0;
      div_d   = '0;
    end else if (tick) begin
      case (mode_q)
        RUN_RED, RUN_GREEN:
          pos_d = (pos_q == PW'(N_LEDS - 1)) ? '0 : pos_q + 1'b1;
        ALTERNATE, BLINK:
          phase_d = ~phase_q;
        BOUNCE: begin
          // Reflect at either end so the end LEDs are not lit twice in a row.
          if (N_LEDS > 1) begin
            if (dir_q == UP) begin
              if (pos_q == PW'(N_LEDS - 1)) begin
                dir_d = DOWN;
                pos_d = PW'(N_LEDS - 2);
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end else begin
              if (pos_q == '0) begin
                dir_d = UP;
                pos_d = PW'(1);
              end else begin
                pos_d = pos_q - 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    onehot    = '0;
    even_mask = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      onehot[i]    = (pos_q == PW'(i));
      even_mask[i] = ~i[0];
    end
    red_d   = '0;
    green_d = '0;
    case (mode_q)
      RUN_RED, BOUNCE: red_d = onehot;
      RUN_GREEN:       green_d = onehot;
      ALTERNATE: begin
        red_d   = phase_q ? ~even_mask : even_mask;
        green_d = phase_q ? even_mask : ~even_mask;
      end
      BLINK: begin
        if (phase_q) green_d = '1;
        else         red_d   = '1;
      end
      default: ;
    endcase
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_girlanda_multi.sv
// Bench for girlanda_multi: a 4-pair and a 1-pair instance share clock, reset
// and button; expected LED states are queued per cycle and popped on sampling.
module tb_girlanda_multi;

  localparam int DEB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       button = 1'b1;
  logic [3:0] red, green;
  logic [2:0] mode;
  logic [0:0] red1, green1;
  logic [2:0] mode1;

  girlanda_multi #(.N_LEDS(4), .STEP_DIV(8), .DEBOUNCE(DEB)) dut (
    .clk(clk), .reset(reset), .button(button),
    .red(red), .green(green), .mode(mode)
  );

  girlanda_multi #(.N_LEDS(1), .STEP_DIV(8), .DEBOUNCE(DEB)) dut1 (
    .clk(clk), .reset(reset), .button(button),
    .red(red1), .green(green1), .mode(mode1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic       r1;
    logic       g1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_mode = 0;
  int   k = 0;
  int   since_fall = 0;
  bit   fall_seen = 0;
  bit   armed = 0;

  // Expected LEDs for the kk-th sample after a pattern restart (kk >= 1).
  function automatic exp_t pattern(input int m, input int kk);
    exp_t e;
    int   s, p;
    bit   ev;
    e  = '0;
    s  = (kk - 1) / 8;
    ev = (s % 2 == 0);
    case (m)
      0: begin e.r = 4'(1 << (s % 4)); e.r1 = 1'b1; end
      1: begin e.g = 4'(1 << (s % 4)); e.g1 = 1'b1; end
      2: begin
        e.r  = ev ? 4'b0101 : 4'b1010;
        e.g  = ev ? 4'b1010 : 4'b0101;
        e.r1 = ev;
        e.g1 = !ev;
      end
      3: begin
        p = s % 6;
        if (p > 3) p = 6 - p;
        e.r  = 4'(1 << p);
        e.r1 = 1'b1;
      end
      default: begin
        e.r  = ev ? 4'hF : 4'h0;
        e.g  = ev ? 4'h0 : 4'hF;
        e.r1 = ev;
        e.g1 = !ev;
      end
    endcase
    return e;
  endfunction

  task automatic step_cycle(input logic b);
    exp_t e;
    @(negedge clk);
    if (fall_seen) since_fall++;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = sb.pop_front();
      if (red !== e.r) begin
        failures++;
        $display("FAIL red got %b want %b mode %0d at %0t", red, e.r, exp_mode, $time);
      end
      checks++;
      if (green !== e.g) begin
        failures++;
        $display("FAIL green got %b want %b mode %0d at %0t", green, e.g, exp_mode, $time);
      end
      checks++;
      if (red1 !== e.r1 || green1 !== e.g1) begin
        failures++;
        $display("FAIL n1_leds got r=%b g=%b want r=%b g=%b at %0t",
                 red1, green1, e.r1, e.g1, $time);
      end
      checks++;
      if ((red & green) !== 4'b0000) begin
        failures++;
        $display("FAIL overlap got %b want 0000 at %0t", red & green, $time);
      end
    end
    checks++;
    if (mode !== 3'(exp_mode)) begin
      if (armed && since_fall >= DEB && since_fall <= DEB + 3 &&
          mode === 3'((exp_mode + 1) % 5)) begin
        exp_mode = (exp_mode + 1) % 5;
        k        = 0;
        armed    = 0;
      end else begin
        failures++;
        $display("FAIL mode got %0d want %0d at %0t", mode, exp_mode, $time);
      end
    end
    checks++;
    if (mode1 !== 3'(exp_mode)) begin
      failures++;
      $display("FAIL n1_mode got %0d want %0d at %0t", mode1, exp_mode, $time);
    end
    if (fall_seen && since_fall == DEB + 4 && button == 1'b0) begin
      checks++;
      if (armed) begin
        failures++;
        $display("FAIL press_missing got mode %0d want advance within %0d cycles", mode, DEB + 3);
        armed = 0;
      end
    end
    if (button && !b) begin
      fall_seen  = 1;
      since_fall = 0;
      armed      = 1;
    end
    if (!button && b && since_fall < DEB) armed = 0;
    button = b;
    k++;
    sb.push_back(pattern(exp_mode, k));
  endtask

  task automatic apply_reset();
    #2;
    reset     = 1'b0;
    button    = 1'b1;
    armed     = 0;
    fall_seen = 0;
    #1;
    checks++;
    if ({red, green, mode, red1, green1} !== 13'd0) begin
      failures++;
      $display("FAIL reset_immediate got r=%b g=%b m=%0d want all zero", red, green, mode);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({red, green, mode, red1, green1} !== 13'd0) begin
        failures++;
        $display("FAIL reset_hold got r=%b g=%b m=%0d want all zero", red, green, mode);
      end
    end
    reset = 1'b1;
    sb.delete();
    exp_mode = 0;
    k        = 1;
    sb.push_back(pattern(0, 1));
  endtask

  task automatic run(input int n, input logic b);
    repeat (n) step_cycle(b);
  endtask

  task automatic press(input int low, input int high);
    run(low, 1'b0);
    run(high, 1'b1);
  endtask

  task automatic test_reset();
    apply_reset();
    run(40, 1'b1);
  endtask

  task automatic test_press();
    run(5, 1'b1);
    press(25, 60);
  endtask

  task automatic test_glitch();
    apply_reset();
    repeat (5) begin
      run(10, 1'b0);
      run(20, 1'b1);
    end
    run(20, 1'b1);
  endtask

  task automatic test_mode_cycle();
    apply_reset();
    repeat (5) press(25, 575);
  endtask

  task automatic test_hold();
    apply_reset();
    press(200, 60);
  endtask

  // Varying gaps walk the press edge across every divider phase, incl. the tick.
  task automatic test_press_tick();
    apply_reset();
    for (int off = 0; off < 8; off++) press(25, 40 + off);
  endtask

  task automatic test_reset_mid_bounce();
    apply_reset();
    repeat (3) press(25, 40);
    for (int i = 0; i < 200 && !(((k - 1) / 8) % 6 == 2); i++) step_cycle(1'b1);
    step_cycle(1'b1);
    apply_reset();
    run(20, 1'b1);
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_mode_cycle();
    test_hold();
    test_press_tick();
    test_reset_mid_bounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
